// File: rtl/spi_tx_serializer_pkg.sv
// Shared state encoding, widths and output bundle for the SPI transmit serializer.
package spi_tx_serializer_pkg;

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned LEN_W     = 8;
   localparam int unsigned BIT_CNT_W = $clog2(WORD_W);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SHIFT,
      STOP
   } tx_state_t;

   // Line-side outputs, all registered together from the FSM's next-value logic.
   typedef struct packed {
      logic rd_req;
      logic tx_clk;
      logic tx_data;
      logic tx_load;
      logic tx_stop;
      logic busy;
      logic underrun;
   } tx_out_t;

   // Bit-timer counter width; a divide of 1 still needs one counter bit.
   function automatic int unsigned timer_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/spi_tx_serializer_tx_bit_timer.sv
// Half-period timer for TX_CLK: ticks every CLK_DIV cycles and tracks the clock level.
module spi_tx_serializer_tx_bit_timer
   import spi_tx_serializer_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic half_tick,
   output logic phase
);

   localparam int unsigned      CNT_W    = timer_width(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign half_tick = run && (cnt == CNT_LAST);

   // Held cleared outside SHIFT/STOP so every bit and the stop frame start on a low half.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!run) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_tx_serializer.sv
// Drains 16-bit-word messages from a show-ahead FIFO and emits them MSB-first
// on TX_CLK/TX_DATA with a per-word load strobe and an end-of-message stop frame.
module spi_tx_serializer
   import spi_tx_serializer_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              msg_ready,
   input  logic [LEN_W-1:0]  msg_len,
   input  logic [WORD_W-1:0] fifo_q,
   input  logic              fifo_empty,
   output logic              rd_req,
   output logic              tx_clk,
   output logic              tx_data,
   output logic              tx_load,
   output logic              tx_stop,
   output logic              busy,
   output logic              underrun
);

   tx_state_t            state, state_next;
   logic [LEN_W-1:0]     words_left, words_next;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
   logic [WORD_W-1:0]    shreg, shreg_next;
   tx_out_t              out_q, out_next;

   logic timer_run;
   logic half_tick;
   logic phase;

   assign timer_run = (state == SHIFT) || (state == STOP);

   spi_tx_serializer_tx_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) tx_bit_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (timer_run),
      .half_tick (half_tick),
      .phase     (phase)
   );

   // Next-state and next-output logic; outputs reflect the state being entered.
   always_comb begin
      state_next        = state;
      words_next        = words_left;
      bit_cnt_next      = bit_cnt;
      shreg_next        = shreg;
      out_next          = out_q;
      out_next.rd_req   = 1'b0;
      out_next.underrun = 1'b0;

      case (state)
         IDLE: begin
            if (msg_ready && (msg_len != '0)) begin
               words_next    = msg_len;
               out_next.busy = 1'b1;
               state_next    = FETCH;
            end
         end

         FETCH: begin
            if (!fifo_empty) begin
               out_next.rd_req  = 1'b1;
               shreg_next       = fifo_q;
               bit_cnt_next     = BIT_CNT_W'(WORD_W - 1);
               out_next.tx_data = fifo_q[WORD_W-1];
               out_next.tx_load = 1'b0;
               state_next       = SHIFT;
            end else begin
               out_next.underrun = 1'b1;
               out_next.tx_data  = 1'b0;
               out_next.tx_stop  = 1'b1;
               state_next        = STOP;
            end
         end

         SHIFT: begin
            if (half_tick) begin
               if (!phase) begin
                  out_next.tx_clk = 1'b1;
               end else begin
                  out_next.tx_clk = 1'b0;
                  if (bit_cnt != '0) begin
                     bit_cnt_next     = bit_cnt - BIT_CNT_W'(1);
                     shreg_next       = shreg << 1;
                     out_next.tx_data = shreg[WORD_W-2];
                     out_next.tx_load = (bit_cnt == BIT_CNT_W'(1));
                  end else begin
                     out_next.tx_load = 1'b0;
                     words_next       = words_left - LEN_W'(1);
                     if (words_left != LEN_W'(1)) begin
                        state_next = FETCH;
                     end else begin
                        out_next.tx_data = 1'b0;
                        out_next.tx_stop = 1'b1;
                        state_next       = STOP;
                     end
                  end
               end
            end
         end

         STOP: begin
            // Stop frame lasts one full bit period with TX_CLK held low.
            if (half_tick && phase) begin
               out_next.tx_stop = 1'b0;
               out_next.busy    = 1'b0;
               state_next       = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_left <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         out_q      <= '0;
      end else begin
         words_left <= words_next;
         bit_cnt    <= bit_cnt_next;
         shreg      <= shreg_next;
         out_q      <= out_next;
      end
   end

   assign rd_req   = out_q.rd_req;
   assign tx_clk   = out_q.tx_clk;
   assign tx_data  = out_q.tx_data;
   assign tx_load  = out_q.tx_load;
   assign tx_stop  = out_q.tx_stop;
   assign busy     = out_q.busy;
   assign underrun = out_q.underrun;

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Scoreboard bench for spi_tx_serializer: a line-side monitor reassembles words and
// message frames and checks them against events queued when each message is issued.
module tb_spi_tx_serializer;

   localparam int unsigned D        = 2;
   localparam int          WORD_CYC = 32 * D + 1;
   localparam int          EV_WORD  = 0;
   localparam int          EV_UND   = 1;
   localparam int          EV_END   = 2;

   typedef struct {
      int          kind;
      logic [15:0] data;
      int          nwords;
      int          span;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        msg_ready;
   logic [7:0]  msg_len;
   logic [15:0] fifo_q;
   logic        fifo_empty;
   logic        rd_req, tx_clk, tx_data, tx_load, tx_stop, busy, underrun;

   int checks = 0;
   int errors = 0;

   ev_t         exp_q[$];
   logic [15:0] wbuf[$];
   logic [15:0] fmem[256];
   int unsigned fwr = 0;
   int unsigned frd = 0;

   int          cyc = 0;
   int          rise_cyc = 0;
   int          nbits = 0;
   int          nrd = 0;
   int          last_rd = -1;
   int          stop_run = 0;
   int          und_run = 0;
   logic        got_first = 1'b0;
   logic        busy_q = 1'b0, clk_q = 1'b0, stop_q = 1'b0, und_q = 1'b0;
   logic [15:0] cap = '0;

   always #5 clk = ~clk;

   spi_tx_serializer #(
      .CLK_DIV (D)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .msg_ready  (msg_ready),
      .msg_len    (msg_len),
      .fifo_q     (fifo_q),
      .fifo_empty (fifo_empty),
      .rd_req     (rd_req),
      .tx_clk     (tx_clk),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .tx_stop    (tx_stop),
      .busy       (busy),
      .underrun   (underrun)
   );

   // Show-ahead source FIFO model.
   always_comb begin
      fifo_q     = fmem[frd[7:0]];
      fifo_empty = (frd == fwr);
   end

   task automatic check(input string name, input longint got, input longint req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, req, $time);
      end
   endtask

   task automatic pop_exp(input int kind, output ev_t ev, output bit ok);
      ok        = 1'b0;
      ev.kind   = -1;
      ev.data   = '0;
      ev.nwords = 0;
      ev.span   = 0;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_event: got event kind %0d, required none (queue empty, t=%0t)", kind, $time);
      end else begin
         ev = exp_q.pop_front();
         if (ev.kind != kind) begin
            errors++;
            $display("FAIL sb_event: got event kind %0d, required kind %0d (t=%0t)", kind, ev.kind, $time);
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin : fifo_pop
      if (rst_n && rd_req) begin
         check("rd_req_on_nonempty", fifo_empty, 0);
         if (!fifo_empty) frd = frd + 1;
      end
   end

   always @(negedge clk) begin : monitor
      ev_t ev;
      bit  ok;
      if (!rst_n) begin
         busy_q = 1'b0; clk_q = 1'b0; stop_q = 1'b0; und_q = 1'b0;
         nbits = 0; nrd = 0; last_rd = -1; stop_run = 0; und_run = 0; got_first = 1'b0;
      end else begin
         cyc++;
         if (busy && !busy_q) begin
            rise_cyc = cyc; nrd = 0; nbits = 0; last_rd = -1; got_first = 1'b0;
         end
         if (!busy)
            check("idle_outputs", {rd_req, tx_clk, tx_data, tx_load, tx_stop, underrun}, 0);
         if (rd_req) begin
            nrd++;
            if (last_rd >= 0) check("rd_req_spacing", cyc - last_rd, WORD_CYC);
            last_rd = cyc;
            check("rd_req_with_underrun", underrun, 0);
         end
         if (underrun && !und_q) pop_exp(EV_UND, ev, ok);
         if (underrun) und_run++;
         else if (und_q) begin
            check("underrun_width", und_run, 1);
            und_run = 0;
         end
         if (tx_stop) begin
            stop_run++;
            check("tx_clk_low_in_stop", tx_clk, 0);
         end else if (stop_q) begin
            check("tx_stop_width", stop_run, 2 * D);
            stop_run = 0;
         end
         if (tx_clk && !clk_q) begin
            if (!got_first) begin
               check("first_rise_latency", cyc - rise_cyc, 1 + D);
               got_first = 1'b1;
            end
            check("tx_load_position", tx_load, (nbits == 15));
            cap = {cap[14:0], tx_data};
            nbits++;
            if (nbits == 16) begin
               pop_exp(EV_WORD, ev, ok);
               if (ok) check("word_data", cap, ev.data);
               nbits = 0;
            end
         end
         // Span counts the IDLE start cycle plus every busy cycle.
         if (!busy && busy_q) begin
            pop_exp(EV_END, ev, ok);
            if (ok) begin
               check("busy_span", cyc - rise_cyc + 1, ev.span);
               check("rd_req_count", nrd, ev.nwords);
               check("partial_word_bits", nbits, 0);
            end
         end
         busy_q = busy; clk_q = tx_clk; stop_q = tx_stop; und_q = underrun;
      end
   end

   task automatic push_fifo(input logic [15:0] w);
      fmem[fwr[7:0]] = w;
      fwr = fwr + 1;
   endtask

   task automatic push_ev(input int kind, input logic [15:0] data, input int nwords, input int span);
      ev_t e;
      e.kind = kind; e.data = data; e.nwords = nwords; e.span = span;
      exp_q.push_back(e);
   endtask

   // Reference: k words sent, then an underrun if the FIFO ran dry, then the stop frame.
   task automatic expect_msg(input int len, input int navail);
      int k;
      int short_by;
      k        = (navail < len) ? navail : len;
      short_by = (navail < len) ? 1 : 0;
      for (int i = 0; i < k; i++) push_ev(EV_WORD, wbuf[i], 0, 0);
      if (short_by != 0) push_ev(EV_UND, '0, 0, 0);
      push_ev(EV_END, '0, k, 1 + k * WORD_CYC + short_by + 2 * D);
   endtask

   task automatic wait_busy(input logic val, input int limit, input string name);
      int n;
      n = 0;
      while (busy !== val && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, busy, val);
   endtask

   task automatic run_msg(input int len, input int navail);
      for (int i = 0; i < navail; i++) push_fifo(wbuf[i]);
      expect_msg(len, navail);
      @(negedge clk);
      msg_len   = 8'(len);
      msg_ready = 1'b1;
      wait_busy(1'b1, 10, "busy_rise_timeout");
      msg_ready = 1'b0;
      wait_busy(1'b0, 1 + len * WORD_CYC + 2 * D + 20, "busy_fall_timeout");
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish, required finish before 2000000");
      $fatal(1, "simulation timeout");
   end

   initial begin : stim
      int len;
      int navail;
      int n;
      for (int i = 0; i < 256; i++) fmem[i] = '0;
      rst_n     = 1'b0;
      msg_ready = 1'b0;
      msg_len   = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {rd_req, tx_clk, tx_data, tx_load, tx_stop, busy, underrun}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      wbuf.delete(); wbuf.push_back(16'hA5C3);
      run_msg(1, 1);

      wbuf.delete(); wbuf.push_back(16'h0001); wbuf.push_back(16'h8000); wbuf.push_back(16'hFFFF);
      run_msg(3, 3);

      // Zero-length request must be ignored entirely.
      push_fifo(16'h1357);
      msg_len   = 8'd0;
      msg_ready = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("len0_quiet", {busy, rd_req, tx_clk, tx_data, tx_load, tx_stop, underrun}, 0);
      end
      msg_ready = 1'b0;
      check("len0_no_pop", fwr - frd, 1);
      fwr = frd;

      wbuf.delete(); wbuf.push_back(16'h3C5A); wbuf.push_back(16'h9999);
      run_msg(2, 1);

      // Reset during bit 7 of a word.
      wbuf.delete(); wbuf.push_back(16'h5A3C);
      push_fifo(wbuf[0]);
      expect_msg(1, 1);
      @(negedge clk);
      msg_len   = 8'd1;
      msg_ready = 1'b1;
      wait_busy(1'b1, 10, "busy_rise_timeout");
      msg_ready = 1'b0;
      n = 0;
      while (nbits != 8 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reach_bit7_timeout", nbits, 8);
      repeat (D) @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("async_reset_outputs", {rd_req, tx_clk, tx_data, tx_load, tx_stop, busy, underrun}, 0);
      exp_q.delete();
      fwr = frd;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      wbuf.delete(); wbuf.push_back(16'hC0DE);
      run_msg(1, 1);

      // Back-to-back messages with MSG_READY held high.
      wbuf.delete(); wbuf.push_back(16'h1234); wbuf.push_back(16'hBEEF);
      for (int i = 0; i < 2; i++) push_fifo(wbuf[i]);
      expect_msg(2, 2);
      wbuf.delete(); wbuf.push_back(16'h0F0F);
      push_fifo(wbuf[0]);
      expect_msg(1, 1);
      @(negedge clk);
      msg_len   = 8'd2;
      msg_ready = 1'b1;
      wait_busy(1'b1, 10, "busy_rise_timeout");
      msg_len = 8'd1;
      wait_busy(1'b0, 2 * WORD_CYC + 2 * D + 20, "busy_fall_timeout");
      @(negedge clk);
      check("b2b_restart_gap", busy, 1);
      msg_ready = 1'b0;
      wait_busy(1'b0, WORD_CYC + 2 * D + 20, "busy_fall_timeout");
      @(negedge clk);

      for (int m = 0; m < 15; m++) begin
         len    = int'($urandom_range(1, 5));
         navail = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : len;
         wbuf.delete();
         for (int i = 0; i < len; i++) wbuf.push_back(16'($urandom));
         run_msg(len, navail);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("fifo_drained", fwr - frd, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
